// File: rtl/mac_accumulator_if.sv
// Handshake bundle between the multiplier array, the accumulation stage and
// the result consumer. The slave modport is the accumulator's view.
interface mac_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 20,
  parameter int LEN_W  = 8
);
  logic              clear_i;
  logic              sat_en_i;
  logic              prod_valid_i;
  logic              prod_ready_o;
  logic [PROD_W-1:0] prod_i;
  logic              prod_last_i;
  logic              acc_valid_o;
  logic              acc_ready_i;
  logic [ACC_W-1:0]  acc_o;
  logic              acc_ovf_o;
  logic [LEN_W-1:0]  acc_count_o;

  modport slave (
    input  clear_i, sat_en_i, prod_valid_i, prod_i, prod_last_i, acc_ready_i,
    output prod_ready_o, acc_valid_o, acc_o, acc_ovf_o, acc_count_o
  );

  modport master (
    output clear_i, sat_en_i, prod_valid_i, prod_i, prod_last_i, acc_ready_i,
    input  prod_ready_o, acc_valid_o, acc_o, acc_ovf_o, acc_count_o
  );
endinterface

// File: rtl/mac_accumulator.sv
// Accumulation stage of the pipelined MAC: sums a run of unsigned products,
// optionally saturating, and holds the result until the consumer takes it.
//
// state | meaning
// ACCUM | accepting products, registers show the running partial sum
// HOLD  | result presented on acc_o, input stalled until acc_ready_i
module mac_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 20,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mac_accumulator_if.slave    bus
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               prod_ready;
  logic               accept;
  logic [ACC_W:0]     sum;

  // Ready depends only on state and clear so it never waits on prod_valid_i.
  always_comb begin
    prod_ready = (state_q == ACCUM) && !bus.clear_i;
    accept     = bus.prod_valid_i && prod_ready;
    sum        = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod_i};
  end

  // Next-state and datapath update; clear outranks both accept and result take.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (bus.clear_i) begin
      state_d = ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (sum[ACC_W]) begin
              ovf_d = 1'b1;
              acc_d = bus.sat_en_i ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
            end else begin
              acc_d = sum[ACC_W-1:0];
            end
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);
            if (bus.prod_last_i) begin
              state_d = HOLD;
              valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (valid_q && bus.acc_ready_i) begin
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            valid_d = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // State and datapath registers; reset discards any run or held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Outputs come straight from the running registers.
  always_comb begin
    bus.prod_ready_o = prod_ready;
    bus.acc_valid_o  = valid_q;
    bus.acc_o        = acc_q;
    bus.acc_ovf_o    = ovf_q;
    bus.acc_count_o  = cnt_q;
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a vector table for the basic,
// backpressure and clear sequences, plus hand-written long runs and reset.
module tb_mac_accumulator;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 20;
  localparam int LEN_W  = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mac_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  mac_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] prod;
    logic        last;
    logic        clr;
    logic        sat;
    logic        aready;
    logic        exp_ready;
    logic        exp_valid;
    logic [19:0] exp_acc;
    logic        exp_ovf;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] p, input logic l,
                       input logic c, input logic s, input logic ar);
    bus.prod_valid_i = v;
    bus.prod_i       = p;
    bus.prod_last_i  = l;
    bus.clear_i      = c;
    bus.sat_en_i     = s;
    bus.acc_ready_i  = ar;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [19:0] a,
                         input logic o, input logic [7:0] c);
    chk({tag, ".valid"}, 32'(bus.acc_valid_o), 32'(v));
    chk({tag, ".acc"},   32'(bus.acc_o),       32'(a));
    chk({tag, ".ovf"},   32'(bus.acc_ovf_o),   32'(o));
    chk({tag, ".cnt"},   32'(bus.acc_count_o), 32'(c));
  endtask

  // Runs n products of value p with last on the final one; checks the
  // partial state before the final product when n > 1.
  task automatic long_run(input string tag, input int n, input logic [15:0] p,
                          input logic s, input logic [19:0] pre_acc,
                          input logic pre_ovf, input logic [7:0] pre_cnt,
                          input logic check_pre);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1 && check_pre) chk_out({tag, ".pre"}, 1'b0, pre_acc, pre_ovf, pre_cnt);
      drive(1'b1, p, (i == n - 1), 1'b0, s, 1'b0);
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0, s, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;

    // valid prod last clr sat ar | ready | valid acc ovf cnt (after edge)
    vecs.push_back('{1'b1, 16'd3,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'd3,   1'b0, 8'd1});
    vecs.push_back('{1'b1, 16'd5,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'd8,   1'b0, 8'd2});
    vecs.push_back('{1'b1, 16'd7,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'd15,  1'b0, 8'd3});
    vecs.push_back('{1'b0, 16'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'd0,   1'b0, 8'd0});
    vecs.push_back('{1'b0, 16'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'd0,   1'b0, 8'd0});
    vecs.push_back('{1'b1, 16'd100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'd100, 1'b0, 8'd1});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b1, 16'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 20'd100, 1'b0, 8'd1});
    vecs.push_back('{1'b0, 16'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'd0,   1'b0, 8'd0});
    vecs.push_back('{1'b1, 16'd10,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'd10,  1'b0, 8'd1});
    vecs.push_back('{1'b1, 16'd20,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'd30,  1'b0, 8'd2});
    vecs.push_back('{1'b1, 16'd30,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'd0,   1'b0, 8'd0});
    vecs.push_back('{1'b1, 16'd4,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'd4,   1'b0, 8'd1});
    vecs.push_back('{1'b0, 16'd0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 20'd0,   1'b0, 8'd0});
    vecs.push_back('{1'b0, 16'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'd0,   1'b0, 8'd0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("reset", 1'b0, 20'd0, 1'b0, 8'd0);
    chk("reset.ready", 32'(bus.prod_ready_o), 32'd1);
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].prod, vecs[i].last, vecs[i].clr, vecs[i].sat, vecs[i].aready);
      #1;
      chk($sformatf("vec%0d.ready", i), 32'(bus.prod_ready_o), 32'(vecs[i].exp_ready));
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_acc,
              vecs[i].exp_ovf, vecs[i].exp_cnt);
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Saturating run: 16 x 0xFFFF = 0xFFFF0, the 17th overflows and clamps.
    long_run("sat", 17, 16'hFFFF, 1'b1, 20'hFFFF0, 1'b0, 8'd16, 1'b1);
    chk_out("sat.final", 1'b1, 20'hFFFFF, 1'b1, 8'd17);
    chk("sat.ready", 32'(bus.prod_ready_o), 32'd0);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("sat.take", 1'b0, 20'd0, 1'b0, 8'd0);
    chk("sat.bubble_ready", 32'(bus.prod_ready_o), 32'd1);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Wrapping run: 0x10FFEF modulo 2^20.
    long_run("wrap", 17, 16'hFFFF, 1'b0, 20'hFFFF0, 1'b0, 8'd16, 1'b1);
    chk_out("wrap.final", 1'b1, 20'h0FFEF, 1'b1, 8'd17);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("wrap.take", 1'b0, 20'd0, 1'b0, 8'd0);

    // Count saturation: 300 products of 1.
    long_run("len", 300, 16'd1, 1'b1, 20'd0, 1'b0, 8'd0, 1'b0);
    chk_out("len.final", 1'b1, 20'd300, 1'b0, 8'd255);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset while holding a result, between clock edges.
    drive(1'b1, 16'd42, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_out("hold42", 1'b1, 20'd42, 1'b0, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 20'd0, 1'b0, 8'd0);
    chk("async_rst.ready", 32'(bus.prod_ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("post_rst", 1'b1, 20'd6, 1'b0, 8'd1);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Accumulation stage of the pipelined MAC, directly downstream of the combinational array multiplier. Accepts one unsigned product per cycle over a valid/ready handshake, sums a run of products into a wide accumulator with optional saturation, and presents the finished dot-product result over a second handshake. It tracks the run length and reports a sticky overflow flag per run.

## Interface
- PROD_W, 16, width of unsigned product from the multiplier array
- ACC_W, 20, accumulator/result width (ACC_W > PROD_W)
- LEN_W, 8, width of run-length counter
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, asynchronous assert, active-low
- clear_i  input  1  synchronous abort of the current run
- sat_en_i  input  1  1 = saturate on overflow, 0 = wrap modulo 2^ACC_W
- prod_valid_i  input  1  product present
- prod_ready_o  output  1  stage can accept a product
- prod_i  input  PROD_W  unsigned product
- prod_last_i  input  1  qualifies prod_i as last product of the run
- acc_valid_o  output  1  result present
- acc_ready_i  input  1  consumer takes result
- acc_o  output  ACC_W  accumulated result
- acc_ovf_o  output  1  overflow occurred during this run (sticky)
- acc_count_o  output  LEN_W  number of products in this run

## Operation
- Two states: ACCUM, HOLD. Reset state ACCUM.
- ACCUM: prod_ready_o = ~clear_i. Accept = prod_valid_i & prod_ready_o.
- On accept: sum = acc + zero-extended prod_i, computed ACC_W+1 bits wide; carry = bit ACC_W.
  - carry=0: acc <= sum[ACC_W-1:0].
  - carry=1, sat_en_i=1: acc <= all-ones; ovf <= 1.
  - carry=1, sat_en_i=0: acc <= sum[ACC_W-1:0]; ovf <= 1.
  - Once acc is all-ones under saturation it stays all-ones for the rest of the run.
  - count <= count+1, saturating at 2^LEN_W-1 (no wrap).
  - prod_last_i=1: move to HOLD; acc_valid_o <= 1.
- prod_valid_i without prod_last_i in ACCUM simply accumulates. There is no idle state; the run starts with the first accepted product.
- HOLD: prod_ready_o = 0. acc_o, acc_ovf_o, acc_count_o are held stable while acc_valid_o=1.
  - acc_valid_o & acc_ready_i: acc, ovf, and count clear to 0; acc_valid_o <= 0; go to ACCUM.
- clear_i=1 (either state): acc, ovf, and count are zeroed and acc_valid_o <= 0; go to ACCUM. Any product presented that cycle is not accepted. A result in HOLD is discarded. clear_i has priority over accept and over acc_ready_i.
- sat_en_i is sampled per accept; it may change within a run.
- acc_o, acc_ovf_o, and acc_count_o are always driven from the running registers, so they show partial sums during ACCUM. They are meaningful to the consumer only while acc_valid_o=1.

## Timing
- Reset (rst_n low, asynchronous): state ACCUM, acc_o=0, acc_ovf_o=0, acc_count_o=0, acc_valid_o=0. prod_ready_o=1 once clear_i is low.
- Reset asserted mid-run or in HOLD discards all state immediately, with no clock edge required.
- Throughput: 1 product/cycle in ACCUM.
- Latency: the accepted last product is reflected in acc_o with acc_valid_o=1 on the next cycle.
- Result handshake: the result completes on the cycle acc_valid_o & acc_ready_i. prod_ready_o returns high in the following cycle, giving a minimum 1-cycle bubble between runs.
- prod_ready_o is combinational from state and clear_i only. It does not depend on prod_valid_i.
- All other outputs are registered.

## Test plan
- Reset: hold rst_n low, then release -> all outputs 0, prod_ready_o=1, acc_valid_o=0. Pulse rst_n low asynchronously mid-cycle during HOLD -> outputs 0 before the next edge.
- Basic run: products 3, 5, 7 on consecutive cycles, last on 7 -> next cycle acc_valid_o=1, acc_o=15, acc_count_o=3, acc_ovf_o=0, prod_ready_o=0. Then acc_ready_i=1 -> next cycle acc_valid_o=0, acc_o=0, prod_ready_o=1.
- Saturation, sat_en_i=1: 17 products of 0xFFFF -> after 16 products acc_o=0xFFFF0, ovf=0. Final acc_o=0xFFFFF, acc_ovf_o=1, acc_count_o=17.
- Wrap, same stimulus with sat_en_i=0 -> acc_o=0x0FFEF, acc_ovf_o=1, acc_count_o=17.
- Backpressure: finish a run with acc_o=100, then hold acc_ready_i=0 for 5 cycles while prod_valid_i=1 with prod_i=9 -> acc_o stays 100, prod_ready_o=0 throughout, and no product is counted.
- Clear: accumulate 10, 20, then assert clear_i together with prod_valid_i (prod_i=30) -> product not accepted, acc_o=0, acc_count_o=0. Next run 4 (last) -> acc_o=4, acc_count_o=1. Also 300 single-product run of 1 -> acc_count_o saturates at 255, acc_o=300.
